// File: rtl/load_store_unit.sv
// Load/store unit between a RISC-V style core port (little-endian values) and a
// byte-addressed data memory that presents words with the lowest-address byte in bits [31:24].
module load_store_unit #(
    parameter logic ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_error_q, resp_error_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        req_bad_s;

    function automatic logic [31:0] swap32(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    function automatic logic is_illegal(input logic wr, input logic [2:0] f3);
        logic bad;
        if (wr) begin
            bad = (f3 > 3'd2);
        end else begin
            case (f3)
                3'd3, 3'd6, 3'd7: bad = 1'b1;
                default:          bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic bad;
        case (size)
            2'b01:   bad = a[0];
            2'b10:   bad = (a != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad && !ALLOW_MISALIGNED;
    endfunction

    // Memory byte at the address sits in M[31:24]; the core sees the byte-swapped view.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] m);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {{24{m[31]}}, m[31:24]};
            3'd4:    r = {24'd0, m[31:24]};
            3'd1:    r = {{16{m[23]}}, m[23:16], m[31:24]};
            3'd5:    r = {16'd0, m[23:16], m[31:24]};
            3'd2:    r = swap32(m);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] merge_store(input logic [2:0] f3, input logic [31:0] wd,
                                                input logic [31:0] m);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {wd[7:0], m[23:0]};
            3'd1:    r = {wd[7:0], wd[15:8], m[15:0]};
            default: r = swap32(wd);
        endcase
        return r;
    endfunction

    // Next-state and next-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_error_d = resp_error_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        req_bad_s    = is_illegal(req_write, req_funct3) ||
                       is_misaligned(req_funct3[1:0], req_addr[1:0]);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d    = req_write;
                    funct3_d   = req_funct3;
                    wdata_d    = req_wdata;
                    mem_addr_d = req_addr;
                    if (req_bad_s) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = 32'd0;
                    end else if (req_write && (req_funct3 == 3'd2)) begin
                        state_d     = S_WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = swap32(req_wdata);
                    end else begin
                        state_d = S_READ;
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            S_READ: begin
                // Sub-word stores merge their bytes into the word just read.
                if (write_q) begin
                    state_d     = S_WRITE;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_store(funct3_q, wdata_q, mem_read_data);
                end else begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_error_d = 1'b0;
                    resp_rdata_d = load_extend(funct3_q, mem_read_data);
                end
            end
            S_WRITE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_error_d = 1'b0;
                resp_rdata_d = 32'd0;
            end
            S_RESP: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = S_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and registered outputs; reset abandons any in-flight access.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            funct3_q     <= 3'd0;
            wdata_q      <= 32'd0;
            mem_addr_q   <= 32'd0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_error_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_error_q <= resp_error_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready        = req_ready_q;
    assign resp_valid       = resp_valid_q;
    assign resp_rdata       = resp_rdata_q;
    assign resp_error       = resp_error_q;
    assign mem_addr         = mem_addr_q;
    assign mem_write_enable = mem_we_q;
    assign mem_write_data   = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-level reference memory predicts responses,
// write words and latencies; a second instance covers strict alignment.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata, mem_addr, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    logic        m_req_valid, m_req_ready, m_resp_valid, m_resp_error, m_mem_we;
    logic [2:0]  m_req_funct3;
    logic [31:0] m_req_addr, m_resp_rdata, m_mem_addr, m_mem_wdata;
    int          m_we_count = 0;

    logic [7:0]  mem [0:255];
    logic [7:0]  ref_mem [0:255];
    logic        mem_init = 1'b1;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic [31:0] addr;
        int          resp_cyc;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    exp_t resp_q[$];
    wr_t  wr_q[$];

    always #5 clock = ~clock;

    load_store_unit dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
        .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clock(clock), .reset(reset),
        .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(1'b0),
        .req_funct3(m_req_funct3), .req_addr(m_req_addr), .req_wdata(32'd0),
        .resp_valid(m_resp_valid), .resp_rdata(m_resp_rdata), .resp_error(m_resp_error),
        .mem_addr(m_mem_addr), .mem_write_enable(m_mem_we),
        .mem_write_data(m_mem_wdata), .mem_read_data(32'h01020304)
    );

    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        logic [7:0] ra;
        ra = mem_addr[7:0];
        mem_read_data = {mem[ra], mem[ra + 8'd1], mem[ra + 8'd2], mem[ra + 8'd3]};
    end

    always @(posedge clock) begin
        logic [7:0] wa;
        wa = mem_addr[7:0];
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 37 + 5);
        end else if (mem_write_enable) begin
            mem[wa]        <= mem_write_data[31:24];
            mem[wa + 8'd1] <= mem_write_data[23:16];
            mem[wa + 8'd2] <= mem_write_data[15:8];
            mem[wa + 8'd3] <= mem_write_data[7:0];
        end
    end

    always @(posedge clock) if (m_mem_we) m_we_count <= m_we_count + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Response and write-strobe monitor.
    always @(negedge clock) begin
        exp_t e;
        wr_t  w;
        if (!reset && resp_valid) begin
            if (resp_q.size() == 0) begin
                check_eq("resp_unexpected", 32'(resp_q.size()), 32'd1);
            end else begin
                e = resp_q.pop_front();
                check_eq("resp_rdata", resp_rdata, e.rdata);
                check_eq("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                check_eq("resp_addr", mem_addr, e.addr);
                check_eq("resp_latency", 32'(cyc), 32'(e.resp_cyc));
            end
        end
        if (!reset && mem_write_enable) begin
            if (wr_q.size() == 0) begin
                check_eq("write_unexpected", 32'(wr_q.size()), 32'd1);
            end else begin
                w = wr_q.pop_front();
                check_eq("write_addr", mem_addr, w.addr);
                check_eq("write_data", mem_write_data, w.data);
            end
        end
    end

    // Byte-level model of the core-visible memory; updates ref_mem for stores.
    task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, output exp_t e, output logic has_wr,
                         output wr_t w);
        logic [7:0] ix [4];
        logic [7:0] b [4];
        logic       illegal;
        int         lat, nb;
        for (int k = 0; k < 4; k++) begin
            ix[k] = a[7:0] + 8'(k);
            b[k]  = ref_mem[ix[k]];
        end
        illegal = wr ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        e.addr  = a;
        e.err   = illegal;
        e.rdata = 32'd0;
        has_wr  = 1'b0;
        w.addr  = a;
        w.data  = 32'd0;
        if (illegal) begin
            lat = 1;
        end else if (wr) begin
            nb = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
            for (int k = 0; k < nb; k++) ref_mem[ix[k]] = d[8*k +: 8];
            has_wr = 1'b1;
            w.data = {ref_mem[ix[0]], ref_mem[ix[1]], ref_mem[ix[2]], ref_mem[ix[3]]};
            lat    = (f3 == 3'd2) ? 2 : 3;
        end else begin
            lat = 2;
            case (f3)
                3'd0:    e.rdata = {{24{b[0][7]}}, b[0]};
                3'd4:    e.rdata = {24'd0, b[0]};
                3'd1:    e.rdata = {{16{b[1][7]}}, b[1], b[0]};
                3'd5:    e.rdata = {16'd0, b[1], b[0]};
                default: e.rdata = {b[3], b[2], b[1], b[0]};
            endcase
        end
        e.resp_cyc = cyc + lat;
    endtask

    // Present a request (req_valid stays high on return) and log expectations at acceptance.
    task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        exp_t e;
        wr_t  w;
        logic has_wr;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        for (int i = 0; i < 50 && !req_ready; i++) @(negedge clock);
        if (!req_ready) begin
            check_eq("accept_timeout", {31'd0, req_ready}, 32'd1);
            return;
        end
        model(wr, f3, a, d, e, has_wr, w);
        resp_q.push_back(e);
        if (has_wr) wr_q.push_back(w);
        @(negedge clock);
    endtask

    task automatic drain();
        req_valid = 1'b0;
        for (int i = 0; i < 30 && (resp_q.size() != 0 || wr_q.size() != 0 || !req_ready); i++)
            @(negedge clock);
        check_eq("drain_pending", 32'(resp_q.size() + wr_q.size()), 32'd0);
    endtask

    task automatic strict_access(input logic [2:0] f3, input logic [31:0] a,
                                 input logic exp_err, input logic [31:0] exp_rdata);
        logic seen = 1'b0;
        m_req_funct3 = f3;
        m_req_addr   = a;
        m_req_valid  = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock);
            m_req_valid = 1'b0;
            seen = m_resp_valid;
        end
        check_eq("strict_resp_seen", {31'd0, seen}, 32'd1);
        check_eq("strict_error", {31'd0, m_resp_error}, {31'd0, exp_err});
        check_eq("strict_rdata", m_resp_rdata, exp_rdata);
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 37 + 5);
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;
        m_req_valid = 1'b0; m_req_funct3 = 3'd0; m_req_addr = 32'd0;
        #2;
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_rdata", resp_rdata, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_we", {31'd0, mem_write_enable}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        mem_init = 1'b0;

        issue(1'b1, 3'd2, 32'h10, 32'h11223344);
        drain();
        check_eq("mem_after_sw", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h11223344);
        issue(1'b0, 3'd2, 32'h10, 32'd0);
        issue(1'b0, 3'd0, 32'h13, 32'd0);
        issue(1'b0, 3'd1, 32'h10, 32'd0);
        drain();
        issue(1'b1, 3'd0, 32'h30, 32'h00000080);
        issue(1'b0, 3'd0, 32'h30, 32'd0);
        issue(1'b0, 3'd4, 32'h30, 32'd0);
        issue(1'b1, 3'd0, 32'h11, 32'h000000AB);
        issue(1'b0, 3'd2, 32'h10, 32'd0);
        drain();
        check_eq("mem_after_sb", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 32'h1122AB44);
        issue(1'b1, 3'd1, 32'h22, 32'h1234CAFE);
        issue(1'b0, 3'd5, 32'h22, 32'd0);
        issue(1'b0, 3'd1, 32'h22, 32'd0);
        issue(1'b0, 3'd3, 32'h10, 32'd0);
        issue(1'b1, 3'd5, 32'h10, 32'hFFFFFFFF);
        issue(1'b0, 3'd6, 32'h10, 32'd0);
        issue(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF);
        issue(1'b0, 3'd2, 32'h12, 32'd0);
        issue(1'b0, 3'd2, 32'hFFFFFFFE, 32'd0);
        issue(1'b1, 3'd2, 32'hFFFFFFFF, 32'hDEADBEEF);
        issue(1'b0, 3'd2, 32'hFFFFFFFD, 32'd0);
        drain();
        for (int i = 0; i < 24; i++)
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom());
        drain();

        // Reset during the WRITE cycle of an SH must suppress the write.
        req_write = 1'b1; req_funct3 = 3'd1; req_addr = 32'h40; req_wdata = 32'h0000BEEF;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(posedge clock);
        #2;
        check_eq("sh_we_in_write", {31'd0, mem_write_enable}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_mid_we", {31'd0, mem_write_enable}, 32'd0);
        check_eq("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        check_eq("rst_mid_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_eq("rst_mid_error", {31'd0, resp_error}, 32'd0);
        check_eq("rst_mid_rdata", resp_rdata, 32'd0);
        check_eq("rst_mid_addr", mem_addr, 32'd0);
        check_eq("rst_mid_wdata", mem_write_data, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        check_eq("sh_not_written", {mem[8'h40], mem[8'h41]}, {16'd0, ref_mem[8'h40], ref_mem[8'h41]});
        issue(1'b0, 3'd2, 32'h40, 32'd0);
        drain();

        strict_access(3'd2, 32'h12, 1'b1, 32'd0);
        strict_access(3'd1, 32'h13, 1'b1, 32'd0);
        strict_access(3'd1, 32'h12, 1'b0, 32'h00000201);
        strict_access(3'd2, 32'h10, 1'b0, 32'h04030201);
        check_eq("strict_no_write", 32'(m_we_count), 32'd0);

        check_eq("resp_q_empty", 32'(resp_q.size()), 32'd0);
        check_eq("wr_q_empty", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ALLOW_MISALIGNED, default 1: 1 = any byte address accepted; 0 = halfword access with addr[0]=1, or word access with addr[1:0]!=0, is an error.
REQ-002 clock  input  1  single clock; all state updates on posedge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RISC-V funct3: loads 0=LB 1=LH 2=LW 4=LBU 5=LHU; stores 0=SB 1=SH 2=SW.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, little-endian value.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-012 resp_error  output  1  valid with resp_valid; illegal funct3 or rejected misalignment.
REQ-013 mem_addr  output  32  data-memory byte address.
REQ-014 mem_write_enable  output  1  data-memory write strobe; memory writes 4 bytes at posedge.
REQ-015 mem_write_data  output  32  write word; bits [31:24] land at mem_addr+0, [7:0] at mem_addr+3.
REQ-016 mem_read_data  input  32  read word; bits [31:24] hold the byte at mem_addr+0.

Function
REQ-017 FSM states: IDLE, READ, WRITE, RESP; only IDLE asserts req_ready.
REQ-018 IDLE with req_valid=1 latches write, funct3, addr, and wdata; mem_addr takes req_addr on the same edge.
REQ-019 From IDLE, the next state is: RESP for errors, with no memory access; WRITE for SW; READ for all loads and for SB/SH.
REQ-020 READ holds mem_addr and registers mem_read_data at the end of the cycle; then loads go to RESP and SB/SH go to WRITE.
REQ-021 WRITE asserts mem_write_enable for exactly one cycle; then the FSM goes to RESP.
REQ-022 RESP asserts resp_valid for one cycle, then returns to IDLE; resp_rdata and resp_error are held until the next RESP.
REQ-023 Latency from the accept edge T, with resp_valid high in the given cycle: load and SW T+2; SB/SH T+3; error T+1.
REQ-024 mem_write_enable is 0 in every state except WRITE; mem_addr changes only in IDLE on accept.
REQ-025 Byte order: the memory word M={b0,b1,b2,b3} has b0 at the address; the core-visible value is {b3,b2,b1,b0}.
REQ-026 Loads: LB sign-extends M[31:24]; LBU zero-extends it; LH/LHU sign/zero-extend {M[23:16],M[31:24]}; LW returns the byte-swapped M.
REQ-027 Stores: SW writes {wdata[7:0],wdata[15:8],wdata[23:16],wdata[31:24]}.
REQ-028 SB writes {wdata[7:0],M[23:0]} (read-modify-write).
REQ-029 SH writes {wdata[7:0],wdata[15:8],M[15:0]} (read-modify-write).
REQ-030 Illegal funct3 (loads 3,6,7; stores 3-7) sets resp_error=1 and resp_rdata=0.
REQ-031 Rejected misalignment sets resp_error=1 and resp_rdata=0.
REQ-032 req_valid outside IDLE is ignored and not queued; the core holds the request until req_ready.
REQ-033 Address arithmetic wraps modulo 2^32: accesses at 0xFFFFFFFD..0xFFFFFFFF pass through unmodified, and the memory handles the wrap.
REQ-034 Back-to-back requests: a request may be accepted in the first IDLE cycle after RESP.

Reset
REQ-035 On reset assertion, outputs go immediately (asynchronously) to: state IDLE, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0, mem_addr=0, mem_write_enable=0, mem_write_data=0.
REQ-036 Reset in READ or WRITE abandons the access with no write issued after reset; a write strobed before reset is not undone.
REQ-037 The first request is accepted on the first posedge after reset deasserts.

Verification
REQ-038 SW addr=0x10, wdata=0x11223344 -> one write strobe with mem_write_data=0x44332211; resp_valid at T+2; resp_error=0.
REQ-039 After REQ-038: LW 0x10 -> 0x11223344. LB 0x13 -> 0x00000011. LH 0x10 -> 0x00003344. LB to a byte 0x80 -> 0xFFFFFF80, and LBU to that byte -> 0x00000080.
REQ-040 After REQ-038: SB addr=0x11, wdata=0xAB -> READ then WRITE with mem_write_data={0xAB,0x22,0x11,xx}; LW 0x10 -> 0x1122AB44; resp_valid at T+3.
REQ-041 funct3=3 load, and funct3=5 store -> resp_valid at T+1, resp_error=1, no write strobe. With ALLOW_MISALIGNED=0, LW 0x12 -> error; with the default, LW 0x12 succeeds.
REQ-042 Assert reset during the WRITE cycle of an SH -> mem_write_enable falls immediately; outputs are at reset values; a new LW after release completes normally.
REQ-043 Hold req_valid=1 continuously for 3 requests -> each accepted only in IDLE, no request lost or duplicated, responses in order.
